// File: rtl/nest_pkg.sv
// nest_pkg: shared constants and helpers for the keyword-nesting checker.
//  - keyword byte strings (first char at index 0) and their lengths
//  - stack tag encodings, error codes, tracker state encoding
//  - is_delim(), to_lower(), kw_char(), kw_len()
package nest_pkg;

  // Keyword ids, used as the bit position in the tracker match mask
  localparam int KW_ID_BEGIN   = 0;
  localparam int KW_ID_END     = 1;
  localparam int KW_ID_CASE    = 2;
  localparam int KW_ID_ENDCASE = 3;
  localparam int NKW           = 4;

  // Byte strings padded to 8 chars; [0] is the first letter
  localparam logic [0:7][7:0] KW_BEGIN   = {"begin",   24'h0};
  localparam logic [0:7][7:0] KW_END     = {"end",     40'h0};
  localparam logic [0:7][7:0] KW_CASE    = {"case",    32'h0};
  localparam logic [0:7][7:0] KW_ENDCASE = {"endcase",  8'h0};

  localparam logic [2:0] KW_BEGIN_LEN   = 3'd5;
  localparam logic [2:0] KW_END_LEN     = 3'd3;
  localparam logic [2:0] KW_CASE_LEN    = 3'd4;
  localparam logic [2:0] KW_ENDCASE_LEN = 3'd7;

  localparam logic TAG_BEGIN = 1'b0;
  localparam logic TAG_CASE  = 1'b1;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNDER    = 2'b01,
    ERR_MISMATCH = 2'b10,
    ERR_OVER     = 2'b11
  } err_code_e;

  typedef enum logic {
    ST_DELIM = 1'b0,
    ST_WORD  = 1'b1
  } trk_state_e;

  function automatic logic is_delim(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ? (c + 8'h20) : c;
  endfunction

  function automatic logic [7:0] kw_char(input logic [1:0] k, input logic [2:0] i);
    case (k)
      2'd0:    return KW_BEGIN[i];
      2'd1:    return KW_END[i];
      2'd2:    return KW_CASE[i];
      default: return KW_ENDCASE[i];
    endcase
  endfunction

  function automatic logic [2:0] kw_len(input logic [1:0] k);
    case (k)
      2'd0:    return KW_BEGIN_LEN;
      2'd1:    return KW_END_LEN;
      2'd2:    return KW_CASE_LEN;
      default: return KW_ENDCASE_LEN;
    endcase
  endfunction

endpackage

// File: rtl/nest_stack.sv
// nest_stack: DEPTH_MAX x 1-bit LIFO holding the type tag of each open block.
//  clk, reset : clock, synchronous active-high reset (empties the stack)
//  push, din  : push din when not full
//  pop        : drop the top entry when not empty
//  top        : tag of the most recent entry (0 when empty)
//  full/empty : occupancy flags
//  count      : number of entries held
module nest_stack #(
  parameter  int DEPTH_MAX = 8,
  localparam int DW        = $clog2(DEPTH_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          top,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] count
);

  logic [DEPTH_MAX-1:0] data_q, data_d;
  logic [DW-1:0]        count_q, count_d;

  assign full  = (count_q == DW'(DEPTH_MAX));
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    top     = 1'b0;
    // Slot compare instead of direct indexing keeps index widths exact;
    // count_q-1 wraps to all-ones when empty, which no slot matches.
    for (int i = 0; i < DEPTH_MAX; i++)
      if (DW'(i) == count_q - DW'(1)) top = data_q[i];
    if (push && !full) begin
      for (int i = 0; i < DEPTH_MAX; i++)
        if (DW'(i) == count_q) data_d[i] = din;
      count_d = count_q + DW'(1);
    end else if (pop && !empty) begin
      count_d = count_q - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nest_checker.sv
// nest_checker: streaming begin/end + case/endcase nesting checker.
//  clk, reset : clock, synchronous active-high reset
//  in_valid   : qualifies in; nothing changes on edges with in_valid=0
//  in         : ASCII byte
//  result     : stream so far is balanced and error-free, including a
//               keyword still being typed (no trailing delimiter needed)
//  depth      : committed number of open blocks
//  error      : sticky error flag
//  err_code   : first error (none/underflow/mismatch/overflow)
module nest_checker
  import nest_pkg::*;
#(
  parameter  int DEPTH_MAX = 8,
  parameter  int CASE_EN   = 1,
  localparam int DW        = $clog2(DEPTH_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in,
  output logic          result,
  output logic [DW-1:0] depth,
  output logic          error,
  output logic [1:0]    err_code
);

  // Keywords that can ever match; case/endcase drop out when disabled
  localparam logic [NKW-1:0] KW_EN = (CASE_EN != 0) ? 4'b1111 : 4'b0011;

  trk_state_e     st_q, st_d;
  logic [2:0]     idx_q, idx_d;      // chars seen in current word, saturating
  logic [NKW-1:0] mask_q, mask_d;    // keywords still matching
  logic           long_q, long_d;    // word is longer than 7 chars
  logic           error_q, error_d;
  err_code_e      err_code_q, err_code_d;

  logic           stk_push, stk_pop, stk_top, stk_full, stk_empty;
  logic [DW-1:0]  stk_count;

  logic [7:0]     c;
  logic           delim;
  logic [NKW-1:0] pend_hit;
  logic           pend_any, pend_open, pend_close, pend_tag;
  err_code_e      pend_err_code;
  logic           pend_err, pend_push, pend_pop, commit;
  logic [2:0]     pos;
  logic [NKW-1:0] base_mask;
  logic [DW:0]    depth_after;

  nest_stack #(.DEPTH_MAX(DEPTH_MAX)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pend_tag),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .count (stk_count)
  );

  // Pending keyword, decoded from registered tracker state only. Lengths
  // are distinct, so "end" pends at idx 3 even while "endcase" still matches.
  always_comb begin
    for (int k = 0; k < NKW; k++)
      pend_hit[k] = (st_q == ST_WORD) && mask_q[k] && !long_q &&
                    (idx_q == kw_len(2'(k)));
    pend_any   = $onehot(pend_hit);
    pend_open  = pend_any && (pend_hit[KW_ID_BEGIN] || pend_hit[KW_ID_CASE]);
    pend_close = pend_any && (pend_hit[KW_ID_END]   || pend_hit[KW_ID_ENDCASE]);
    pend_tag   = (pend_hit[KW_ID_CASE] || pend_hit[KW_ID_ENDCASE]) ? TAG_CASE : TAG_BEGIN;

    pend_err_code = ERR_NONE;
    if (pend_open && stk_full)                     pend_err_code = ERR_OVER;
    else if (pend_close && stk_empty)              pend_err_code = ERR_UNDER;
    else if (pend_close && (stk_top != pend_tag))  pend_err_code = ERR_MISMATCH;
    pend_err  = (pend_err_code != ERR_NONE);
    pend_push = pend_open  && !pend_err;
    pend_pop  = pend_close && !pend_err;
  end

  assign c        = to_lower(in);
  assign delim    = is_delim(in);
  assign commit   = in_valid && delim && (st_q == ST_WORD);
  assign stk_push = commit && pend_push;
  assign stk_pop  = commit && pend_pop;

  // Word tracker and sticky error
  always_comb begin
    st_d       = st_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    long_d     = long_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    // First char of a word compares against index 0 with every enabled keyword live
    pos        = (st_q == ST_WORD) ? idx_q  : 3'd0;
    base_mask  = (st_q == ST_WORD) ? mask_q : KW_EN;
    if (in_valid) begin
      if (delim) begin
        st_d = ST_DELIM;
      end else begin
        st_d = ST_WORD;
        for (int k = 0; k < NKW; k++)
          mask_d[k] = base_mask[k] && (pos < kw_len(2'(k))) &&
                      (c == kw_char(2'(k), pos));
        if (st_q == ST_WORD) begin
          if (idx_q == 3'd7) long_d = 1'b1;
          else               idx_d  = idx_q + 3'd1;
        end else begin
          idx_d  = 3'd1;
          long_d = 1'b0;
        end
      end
      if (commit && pend_err && !error_q) begin
        error_d    = 1'b1;
        err_code_d = pend_err_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= ST_DELIM;
      idx_q      <= '0;
      mask_q     <= '0;
      long_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      st_q       <= st_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      long_q     <= long_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  // Depth as it would be once the pending keyword commits
  assign depth_after = {1'b0, stk_count} + (DW+1)'(pend_push) - (DW+1)'(pend_pop);
  assign result      = !error_q && !pend_err && (depth_after == '0);
  assign depth       = stk_count;
  assign error       = error_q;
  assign err_code    = err_code_q;

endmodule
